// File: rtl/cordic_arbiter_pkg.sv
// Shared definitions for the CORDIC arbiter: operation codes,
// the highest legal opcode and the arbiter FSM state type.
package cordic_arbiter_pkg;

  localparam logic [3:0] OP_SIN     = 4'd0;
  localparam logic [3:0] OP_COS     = 4'd1;
  localparam logic [3:0] OP_ATAN    = 4'd2;
  localparam logic [3:0] OP_MAG     = 4'd3;
  localparam logic [3:0] OP_MULT    = 4'd4;
  localparam logic [3:0] OP_DIV     = 4'd5;
  localparam logic [3:0] OP_SINH    = 4'd6;
  localparam logic [3:0] OP_COSH    = 4'd7;
  localparam logic [3:0] OP_ATANH   = 4'd8;
  localparam logic [3:0] OP_MODH    = 4'd9;
  localparam logic [3:0] OP_DEFAULT = 4'd15;
  localparam logic [3:0] OP_MAX     = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/cordic_arbiter_rr_grant.sv
// Round-robin picker: first requester at or after ptr_i (wrapping).
// Ports: req_i/ptr_i in; one-hot gnt_o, idx_o and any_o out.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC calculator among NUM_REQ requesters, one op at a time.
// Ports: req_* (requesters), rsp_* (response), cdc_* (CORDIC side).
// Optional: define CORDIC_ARB_TIMEOUT_EN to bound the wait for cdc_done.
module cordic_arbiter
  import cordic_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_x,
  input  logic [WIDTH*NUM_REQ-1:0]   req_y,
  input  logic [WIDTH*NUM_REQ-1:0]   req_z,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_err,
  output logic                       cdc_enable,
  output logic [3:0]                 cdc_operation,
  output logic [WIDTH-1:0]           cdc_x,
  output logic [WIDTH-1:0]           cdc_y,
  output logic [WIDTH-1:0]           cdc_z,
  input  logic [WIDTH-1:0]           cdc_result,
  input  logic                       cdc_done
);

  localparam int IW = $clog2(NUM_REQ);

  logic [3:0]       op_arr [NUM_REQ];
  logic [WIDTH-1:0] x_arr  [NUM_REQ];
  logic [WIDTH-1:0] y_arr  [NUM_REQ];
  logic [WIDTH-1:0] z_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[g*4 +: 4];
    assign x_arr[g]  = req_x[g*WIDTH +: WIDTH];
    assign y_arr[g]  = req_y[g*WIDTH +: WIDTH];
    assign z_arr[g]  = req_z[g*WIDTH +: WIDTH];
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               gany;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    res_d     = res_q;
    err_d     = err_q;
    req_ready = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gany) begin
          req_ready = gnt;
          id_d      = gidx;
          op_d      = op_arr[gidx];
          x_d       = x_arr[gidx];
          y_d       = y_arr[gidx];
          z_d       = z_arr[gidx];
          if (op_arr[gidx] > OP_MAX) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A done seen here belongs to nothing we issued.
        state_d = S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (cdc_done) begin
          res_d   = cdc_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (tmo) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (id_q == IW'(NUM_REQ - 1)) ptr_d = '0;
          else                          ptr_d = id_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  logic busy;
  assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Operands are only presented while the CORDIC owns the op.
  assign cdc_enable    = (state_q == S_ISSUE);
  assign cdc_operation = busy ? op_q : '0;
  assign cdc_x         = busy ? x_q  : '0;
  assign cdc_y         = busy ? y_q  : '0;
  assign cdc_z         = busy ? z_q  : '0;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a delayed-done CORDIC stub.
// Define CORDIC_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_cordic_arbiter;
  import cordic_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int TMO = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_x, req_y, req_z;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           cdc_enable;
  logic [3:0]     cdc_operation;
  logic [W-1:0]   cdc_x, cdc_y, cdc_z;
  logic [W-1:0]   cdc_result;
  logic           cdc_done;

  cordic_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .cdc_enable(cdc_enable), .cdc_operation(cdc_operation),
    .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
    .cdc_result(cdc_result), .cdc_done(cdc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  always @(posedge clk) if (cdc_enable) en_cnt <= en_cnt + 1;

  int          stub_delay = 1;
  logic [31:0] stub_res = '0;
  bit          stub_never = 1'b0;

  initial begin : stub
    int d;
    logic [31:0] r;
    cdc_done   = 1'b0;
    cdc_result = '0;
    forever begin
      @(negedge clk);
      if (cdc_enable && !stub_never) begin
        d = stub_delay;
        r = stub_res;
        repeat (d) @(negedge clk);
        cdc_done   = 1'b1;
        cdc_result = r;
        @(negedge clk);
        cdc_done   = 1'b0;
      end
    end
  end

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [31:0] x, y, z;
    logic [31:0] res;
    int          dly;
    bit          never;
    logic        exp_err;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(
    input int idx, input logic [3:0] op,
    input logic [31:0] x, input logic [31:0] y,
    input logic [31:0] z, input logic [31:0] res,
    input int dly, input bit never,
    input logic exp_err, input logic [31:0] exp_res,
    input int exp_lat);
    vec_t v;
    v.idx = idx; v.op = op; v.x = x; v.y = y; v.z = z;
    v.res = res; v.dly = dly; v.never = never;
    v.exp_err = exp_err; v.exp_res = exp_res;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [31:0] z);
    req_op[idx*4 +: 4]  = op;
    req_x[idx*W +: W]   = x;
    req_y[idx*W +: W]   = y;
    req_z[idx*W +: W]   = z;
  endtask

  function automatic logic any_out();
    return |{req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
             cdc_enable, cdc_operation, cdc_x, cdc_y, cdc_z};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 300);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int e0;
    logic [3:0] g;
    @(negedge clk);
    stub_delay = v.dly;
    stub_res   = v.res;
    stub_never = v.never;
    set_req(v.idx, v.op, v.x, v.y, v.z);
    req_valid[v.idx] = 1'b1;
    #1;
    g = 4'b0001 << v.idx;
    chk("grant", req_ready, g);
    e0 = en_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid[v.idx] = 1'b0;
        if (v.op <= OP_MAX) begin
          chk("issue_en", cdc_enable, 1);
          chk("issue_op", cdc_operation, v.op);
          chk("issue_x", cdc_x, v.x);
          chk("issue_y", cdc_y, v.y);
          chk("issue_z", cdc_z, v.z);
        end else begin
          chk("inv_no_enable", cdc_enable, 0);
        end
      end
    end while (!rsp_valid && n < 300);
    chk("latency", n, v.exp_lat);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.idx);
    chk("rsp_result", rsp_result, v.exp_res);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("ready_busy", req_ready, 0);
    chk("enable_pulses", en_cnt - e0, (v.op <= OP_MAX) ? 1 : 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_released", rsp_valid, 0);
    stub_never = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int got[5];
    int k, cyc, n, bad;
    logic [3:0] g;

    vecs[0] = mk(0, OP_MULT, 32'h00030000, 32'h0, 32'h00050000,
                 32'h000F0000, 30, 0, 1'b0, 32'h000F0000, 32);
    vecs[1] = mk(2, 4'hA, 32'h1, 32'h2, 32'h3,
                 32'h0000FFFF, 5, 0, 1'b1, 32'h0, 1);
    vecs[2] = mk(1, OP_SIN, 32'h0, 32'h0, 32'h0001921F,
                 32'h0000FFFF, 5, 0, 1'b0, 32'h0000FFFF, 7);
    vecs[3] = mk(3, OP_DEFAULT, 32'h5, 32'h6, 32'h7,
                 32'h0, 2, 0, 1'b1, 32'h0, 1);
    vecs[4] = mk(0, OP_MODH, 32'h00020000, 32'h00030000, 32'h0,
                 32'hDEADBEEF, 1, 0, 1'b0, 32'hDEADBEEF, 3);
    vecs[5] = mk(3, OP_COS, 32'h0, 32'h0, 32'h00008000,
                 32'h12345678, 12, 0, 1'b0, 32'h12345678, 14);

    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op = '0;
    req_x = '0;
    req_y = '0;
    req_z = '0;
    #1;
    chk("por_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

`ifdef CORDIC_ARB_TIMEOUT_EN
    run_txn(mk(1, OP_ATAN, 32'h00010000, 32'h00010000, 32'h0,
               32'hBAD0BAD0, 0, 1, 1'b1, 32'h0, TMO + 2));
    run_txn(mk(2, OP_MAG, 32'h00030000, 32'h00040000, 32'h0,
               32'h00050000, 4, 0, 1'b0, 32'h00050000, 6));
`endif

    // Fairness: everyone requests continuously from reset.
    apply_reset();
    stub_delay = 2;
    stub_res   = 32'h00010000;
    rsp_ready  = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, OP_MULT, 32'h00010000, 32'h0, 32'h00010000);
    @(negedge clk);
    req_valid = 4'hF;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 400) begin
      #1;
      if (req_ready != 0) begin
        got[k] = 99;
        for (int j = 0; j < N; j++)
          if (req_ready == (4'b0001 << j)) got[k] = j;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order_%0d", i), got[i], i % 4);
    repeat (10) @(negedge clk);
    rsp_ready = 1'b0;

    // Backpressure with req1 pending behind an invalid op on req0.
    apply_reset();
    set_req(0, 4'hA, 32'h0, 32'h0, 32'h0);
    set_req(1, OP_SIN, 32'h0, 32'h0, 32'h00004000);
    stub_delay = 3;
    stub_res   = 32'hCAFE0001;
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    chk("bp_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_result,
                      req_ready}, {1'b1, 2'd0, 1'b1, 32'h0, 4'h0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("bp_rsp_id", rsp_id, 1);
    chk("bp_rsp_res", rsp_result, 32'hCAFE0001);
    chk("bp_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while waiting on the CORDIC.
    apply_reset();
    run_txn(mk(1, OP_COS, 32'h0, 32'h0, 32'h0,
               32'h00001111, 2, 0, 1'b0, 32'h00001111, 4));
    set_req(0, OP_MULT, 32'h00020000, 32'h0, 32'h00020000);
    stub_delay = 20;
    stub_res   = 32'h11111111;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("mw_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mw_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || cdc_enable) bad++;
    end
    chk("mw_late_done_ignored", bad, 0);
    for (int i = 0; i < N; i++)
      set_req(i, OP_DIV, 32'h00060000, 32'h0, 32'h00020000);
    stub_delay = 2;
    stub_res   = 32'h00030000;
    @(negedge clk);
    req_valid = 4'b1101;
    #1;
    g = req_ready;
    chk("mw_next_grant0", g, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("mw_rsp_id", rsp_id, 0);
    chk("mw_rsp_res", rsp_result, 32'h00030000);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_REQ, 4, number of requesters; WIDTH, 32, operand/result width, Q16.16; TIMEOUT_CYCLES, 64, maximum cycles to wait for cdc_done.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_op  in  4*NUM_REQ  operation codes 0..9 (SIN..MODH).
- req_x, req_y, req_z  in  WIDTH*NUM_REQ  operands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_result  out  WIDTH  result.
- rsp_err  out  1  invalid-op or timeout flag.
- cdc_enable  out  1  start pulse to the shared CORDIC calculator.
- cdc_operation  out  4  operation code to the CORDIC.
- cdc_x, cdc_y, cdc_z  out  WIDTH  operands to the CORDIC.
- cdc_result  in  WIDTH  CORDIC result.
- cdc_done  in  1  CORDIC completion.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; exactly one operation SHALL be in flight at a time.
REQ-004 In IDLE with any req_valid high, the block SHALL grant round-robin, starting at the index after the last granted one (index 0 after reset).
- It SHALL assert req_ready[g] combinationally in that cycle, latch that requester's op and x/y/z, and latch g as rsp_id.
REQ-005 If the latched op > 9, the block SHALL go IDLE->RESP with rsp_err=1 and rsp_result=0, and SHALL NOT pulse cdc_enable.
REQ-006 Otherwise it SHALL enter ISSUE and assert cdc_enable high for exactly one cycle.
- cdc_operation and cdc_x/y/z SHALL hold the latched values from ISSUE until leaving WAIT.
REQ-007 cdc_done SHALL be ignored in the ISSUE cycle.
- In WAIT, the first cycle with cdc_done=1 SHALL capture cdc_result into rsp_result with rsp_err=0 and move to RESP.
REQ-008 In RESP, rsp_valid SHALL stay high with rsp_id, rsp_result and rsp_err stable until rsp_ready=1.
- On that handshake the block SHALL update the round-robin pointer and return to IDLE; req_ready SHALL be 0 outside IDLE.
REQ-009 Latency: request accepted at cycle T, cdc_enable at T+1, done seen at D, rsp_valid at D+1 (invalid op: rsp_valid at T+1).
REQ-010 A request deasserted before grant SHALL be dropped silently; requests held during a busy period SHALL remain pending.

Reset
REQ-011 rst_n low SHALL asynchronously force: state IDLE, pointer 0, and every output 0 (req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, cdc_enable, cdc_operation=0, cdc_x/y/z).
REQ-012 Reset in any state, including mid-WAIT, SHALL abandon the in-flight operation with no response emitted; after release, cdc_done SHALL be ignored until a new ISSUE.

Configuration
REQ-013 With the macro CORDIC_ARB_TIMEOUT_EN defined, a counter SHALL clear on ISSUE and increment each WAIT cycle.
- On reaching TIMEOUT_CYCLES without cdc_done, the block SHALL go to RESP with rsp_err=1 and rsp_result=0.
REQ-014 Without CORDIC_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL wait indefinitely for cdc_done.

Structure
REQ-015 A shared package SHALL hold the operation-code constants (SIN=0 … MODH=9, DEFAULT=15), the OP_MAX=9 constant and the FSM state typedef.
REQ-016 Round-robin selection SHALL be a sub-module rr_grant (inputs request vector and pointer; output one-hot grant plus index).

Verification
REQ-017 Single-op: req0 MULT x=3.0 (0x00030000), z=5.0, stub returns 0x000F0000 after 30 cycles -> one cdc_enable pulse, rsp_valid with rsp_id=0, rsp_result=0x000F0000, rsp_err=0.
REQ-018 Fairness: all four req_valid held high from reset -> grants in order 0,1,2,3,0; no requester granted twice before the others.
REQ-019 Invalid op: req2 op=4'hA -> rsp_valid the next cycle, rsp_id=2, rsp_err=1, rsp_result=0, cdc_enable never asserted.
REQ-020 Timeout (macro on): stub never raises cdc_done -> rsp_err=1 at 64 WAIT cycles + 1; next request is served normally.
REQ-021 Backpressure: rsp_ready low for 10 cycles with req1 pending -> response held stable, req_ready stays 0, req1 granted after the handshake.
REQ-022 Reset mid-WAIT: rst_n low for 2 cycles -> all outputs 0 immediately, no rsp_valid, a late cdc_done ignored, the next grant goes to index 0.
